// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for sram_param_clr; SRAM_OUT_REG_EN selects the read latency
package sram_pkg;

    typedef enum logic {
        CLR = 1'b0,
        RDY = 1'b1
    } clr_state_t;

`ifdef SRAM_OUT_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    function automatic int byte_cnt(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/sram_clr_ctrl.sv
// rtl/sram_clr_ctrl.sv - clear FSM and row counter that walks rows [0, CLR_DEPTH) writing zero
module sram_clr_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int CLR_DEPTH = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(CLR_DEPTH - 1);

    clr_state_t        state;
    logic [ADDR_W-1:0] clr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLR;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
        end else begin
            case (state)
                CLR: begin
                    if (clr_cnt == LAST_ROW) begin
                        state    <= RDY;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                RDY: begin
                    if (clr_req) begin
                        state    <= CLR;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b1;
                    end
                end
            endcase
        end
    end

    // clr_busy is high exactly while in CLR, so it doubles as the clear write strobe
    assign clr_we   = clr_busy;
    assign clr_addr = clr_cnt;

endmodule

// File: rtl/sram_param_clr.sv
// rtl/sram_param_clr.sv - single-port SRAM with byte mask, registered read and clear engine; SRAM_OUT_REG_EN adds an output stage
module sram_param_clr
    import sram_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int DEPTH     = 2048,
    parameter int ADDR_W    = 11,
    parameter int CLR_DEPTH = 36
) (
    input  logic                        CLK,
    input  logic                        sram_reset_n,
    input  logic                        CEN,
    input  logic                        WEN,
    input  logic [ADDR_W-1:0]           A,
    input  logic [DATA_W-1:0]           D,
    input  logic [byte_cnt(DATA_W)-1:0] BWEN,
    input  logic                        clr_req,
    output logic [DATA_W-1:0]           Q,
    output logic                        q_valid,
    output logic                        clr_busy
);

    localparam int NB    = byte_cnt(DATA_W);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  clr_idx;
    logic              in_range;
    logic              access;
    logic              wr_en;
    logic              rd_en;

    sram_clr_ctrl #(
        .ADDR_W    (ADDR_W),
        .CLR_DEPTH (CLR_DEPTH)
    ) u_clr_ctrl (
        .clk      (CLK),
        .rst_n    (sram_reset_n),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign in_range = {1'b0, A} < (ADDR_W + 1)'(DEPTH);
    assign idx      = A[IDX_W-1:0];
    assign clr_idx  = clr_addr[IDX_W-1:0];
    assign access   = !clr_busy && !CEN;
    assign wr_en    = access && !WEN && in_range;
    assign rd_en    = access && WEN;

    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (!BWEN[k]) begin
                    mem[idx][8*k +: 8] <= D[8*k +: 8];
                end
            end
        end
    end

    // Out-of-range reads still complete, but return zero instead of an aliased row
    logic [DATA_W-1:0] rd_q;
    logic              rd_v;

    always_ff @(posedge CLK or negedge sram_reset_n) begin
        if (!sram_reset_n) begin
            rd_q <= '0;
            rd_v <= 1'b0;
        end else begin
            rd_v <= rd_en;
            if (rd_en) begin
                rd_q <= in_range ? mem[idx] : '0;
            end
        end
    end

`ifdef SRAM_OUT_REG_EN
    logic [DATA_W-1:0] out_q;
    logic              out_v;

    always_ff @(posedge CLK or negedge sram_reset_n) begin
        if (!sram_reset_n) begin
            out_q <= '0;
            out_v <= 1'b0;
        end else begin
            out_v <= rd_v;
            if (rd_v) begin
                out_q <= rd_q;
            end
        end
    end

    assign Q       = out_q;
    assign q_valid = out_v;
`else
    assign Q       = rd_q;
    assign q_valid = rd_v;
`endif

endmodule
